// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM state encoding and the default reset fetch address.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc to an external combinational memory and buffers one word for the decoder.
// Defining FETCH_TRACE_EN compiles in a simulation trace of captures, redirects and fault entry.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned       MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] ins,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_ins,
  output logic [WORD_W-1:0] out_pc,
  output logic              fault
);

  // One extra bit so a MEM_WORDS of 65536 still compares correctly.
  localparam logic [WORD_W:0] MEM_LIMIT = (WORD_W+1)'(MEM_WORDS);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_outIns;
  logic [WORD_W-1:0] r_outPc;
  logic              r_outValid;
  logic              r_fault;

  logic w_canAccept;
  logic w_capture;
  logic w_inRange;
  logic w_drained;

  assign w_canAccept = !r_outValid || out_ready;
  assign w_capture   = (r_state == ST_RUN) && !redirect_valid && !halt_req && w_canAccept;
  assign w_inRange   = {1'b0, r_pc} < MEM_LIMIT;
  assign w_drained   = r_outValid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_outIns   <= '0;
      r_outPc    <= '0;
      r_outValid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN, ST_HALT: begin
          if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_outValid <= 1'b0;
            r_state    <= halt_req ? ST_HALT : ST_RUN;
          end else if (w_capture) begin
            if (w_inRange) begin
              r_outIns   <= ins;
              r_outPc    <= r_pc;
              r_outValid <= 1'b1;
              r_pc       <= r_pc + 1'b1;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end else begin
            // Covers halt entry, the halted idle cycles and the stall; a pending entry drains normally.
            if (halt_req) r_state <= ST_HALT;
            if (w_drained) r_outValid <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (w_drained) r_outValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_capture && w_inRange)
        $display("fetch: capture ins=%b pc=%b", ins, r_pc);
      if (redirect_valid && (r_state == ST_RUN || r_state == ST_HALT))
        $display("fetch: redirect to pc=%b", redirect_pc);
      if (w_capture && !w_inRange)
        $display("fetch: FAULT entry at pc=%b", r_pc);
    end
  end
`endif

  assign pc        = r_pc;
  assign out_valid = r_outValid;
  assign out_ins   = r_outIns;
  assign out_pc    = r_outPc;
  assign fault     = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, a hand-written fault sequence and a randomized run
// checked against a transaction-level model of the fetch buffer.
module tb_fetch_unit;

  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] ins;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ins;
  logic [15:0] out_pc;
  logic        fault;

  int passCount  = 0;
  int checkCount = 0;

  fetch_unit #(.RESET_PC(16'h0000), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ins(ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: an odd multiplier makes every address hold a distinct word.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  assign ins = memWord(pc);

  // Reference model: an operating mode plus a 0/1-entry queue standing for the decoder buffer.
  typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mode_t;
  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } entry_t;

  mode_t       mMode;
  logic [15:0] mPc;
  logic        mFault;
  entry_t      mQ[$];

  task automatic modelEdge(input logic r, input logic rv, input logic [15:0] rpc,
                           input logic h, input logic rd);
    entry_t e;
    if (r) begin
      mMode = M_IDLE; mPc = 16'h0000; mFault = 1'b0; mQ.delete();
      return;
    end
    case (mMode)
      M_IDLE:  mMode = M_RUN;
      M_FAULT: if (rd) mQ.delete();
      default: begin
        if (rv) begin
          mPc = rpc; mQ.delete();
          mMode = h ? M_HALT : M_RUN;
        end else if (mMode == M_HALT || h) begin
          if (rd) mQ.delete();
          mMode = M_HALT;
        end else if (mQ.size() == 0 || rd) begin
          if (int'(mPc) < MEM_WORDS) begin
            e.ins = memWord(mPc); e.pc = mPc;
            mQ.delete(); mQ.push_back(e);
            mPc = mPc + 16'd1;
          end else begin
            mMode = M_FAULT; mFault = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [15:0] rpc,
                               input logic h, input logic rd);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt_req = h; out_ready = rd;
    modelEdge(r, rv, rpc, h, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkModel(input int cyc);
    checkOutput($sformatf("rand%0d_pc", cyc), 32'(pc), 32'(mPc));
    checkOutput($sformatf("rand%0d_valid", cyc), 32'(out_valid), 32'(mQ.size() != 0));
    checkOutput($sformatf("rand%0d_fault", cyc), 32'(fault), 32'(mFault));
    if (mQ.size() != 0) begin
      checkOutput($sformatf("rand%0d_out_ins", cyc), 32'(out_ins), 32'(mQ[0].ins));
      checkOutput($sformatf("rand%0d_out_pc", cyc), 32'(out_pc), 32'(mQ[0].pc));
    end
  endtask

  typedef struct {
    logic        vRst, vRv;
    logic [15:0] vRpc;
    logic        vHr, vRdy;
    logic        eValid;
    logic [15:0] eOutPc, ePc;
    logic        eFault;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [15:0] rpc, input logic h,
                              input logic rd, input logic ev, input logic [15:0] eop,
                              input logic [15:0] ep, input logic ef);
    vec_t v;
    v.vRst = r; v.vRv = rv; v.vRpc = rpc; v.vHr = h; v.vRdy = rd;
    v.eValid = ev; v.eOutPc = eop; v.ePc = ep; v.eFault = ef;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0; halt_req = 1'b0; out_ready = 1'b0;

    //                rst rv  rpc      hr  rdy  valid outPc    pc       fault
    // reset then streaming from address 0, first valid on the 2nd edge
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'(i), 16'(i + 1), 0));
    // three stalled cycles at out_pc=5, then resume
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0005, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0006, 16'h0007, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0007, 16'h0008, 0));
    // redirect while stalled at out_pc=7 flushes, target appears one edge later
    vecs.push_back(mk(0, 1, 16'h0100, 0, 0,  0, 16'h0000, 16'h0100, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h0100, 16'h0101, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0101, 16'h0102, 0));
    // halt with pc=10 and an entry pending, drain it, then redirect to 20
    vecs.push_back(mk(0, 1, 16'h0009, 0, 1,  0, 16'h0000, 16'h0009, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h0009, 16'h000A, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0009, 16'h000A, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h0009, 16'h000A, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h000A, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h000A, 0));
    vecs.push_back(mk(0, 1, 16'h0014, 0, 1,  0, 16'h0000, 16'h0014, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0014, 16'h0015, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0015, 16'h0016, 0));
    // halt and redirect together: load target, stay halted
    vecs.push_back(mk(0, 1, 16'h0030, 1, 0,  0, 16'h0000, 16'h0030, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0030, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0030, 0));
    // last valid word, then fault with the entry still held; redirect/halt ignored
    vecs.push_back(mk(0, 1, 16'h03FF, 0, 1,  0, 16'h0000, 16'h03FF, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h03FF, 16'h0400, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h03FF, 16'h0400, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h03FF, 16'h0400, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0,  1, 16'h03FF, 16'h0400, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1,  0, 16'h0000, 16'h0400, 1));
    vecs.push_back(mk(0, 1, 16'h0010, 0, 1,  0, 16'h0000, 16'h0400, 1));
    // reset overrides a simultaneous redirect in FAULT
    vecs.push_back(mk(1, 1, 16'h0055, 0, 1,  0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0000, 16'h0001, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vRst, vecs[i].vRv, vecs[i].vRpc, vecs[i].vHr, vecs[i].vRdy);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].ePc));
      checkOutput($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].eFault));
      if (vecs[i].eValid) begin
        checkOutput($sformatf("vec%0d_out_pc", i), 32'(out_pc), 32'(vecs[i].eOutPc));
        checkOutput($sformatf("vec%0d_out_ins", i), 32'(out_ins), 32'(memWord(vecs[i].eOutPc)));
      end
      if (i == 0) begin
        checkOutput("reset_out_ins", 32'(out_ins), 32'h0);
        checkOutput("reset_out_pc", 32'(out_pc), 32'h0);
      end
    end

    // Redirect straight to the first out-of-range address, a later redirect is ignored, reset recovers.
    applyStimulus(0, 1, 16'h0400, 0, 1);
    checkOutput("oor_redirect_pc", 32'(pc), 32'h0400);
    checkOutput("oor_redirect_fault", 32'(fault), 32'h0);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("oor_fault_set", 32'(fault), 32'h1);
    checkOutput("oor_fault_valid", 32'(out_valid), 32'h0);
    applyStimulus(0, 1, 16'h0005, 0, 1);
    applyStimulus(0, 0, 16'h0000, 0, 1);
    checkOutput("oor_redirect_ignored_pc", 32'(pc), 32'h0400);
    checkOutput("oor_redirect_ignored_valid", 32'(out_valid), 32'h0);
    applyStimulus(1, 0, 16'h0000, 0, 1);
    checkOutput("oor_reset_fault", 32'(fault), 32'h0);
    checkOutput("oor_reset_pc", 32'(pc), 32'h0000);

    // Randomized traffic against the model; occasional resets pull it out of FAULT.
    for (int c = 0; c < 3000; c++) begin
      logic r, rv, h, rd;
      logic [15:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      if (mMode == M_FAULT && $urandom_range(0, 9) == 0) r = 1'b1;
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1000, 1030))
                                        : 16'($urandom_range(0, 1023));
      h   = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      applyStimulus(r, rv, rpc, h, rd);
      checkModel(c);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
